// File: rtl/uart_pkg.sv
// uart_pkg: encodings and constants shared by the UART receive and transmit paths.
//   - Frame-state encodings: IDLE, START_BIT, DATA_BITS, STOP_BIT, and BREAK (receive side only).
//   - DATA_BITS_N: the number of data bits in each frame.
//   - maj3: a 2-of-3 majority helper, used when UART_RX_MAJORITY_EN is defined.
package uart_pkg;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START_BIT = 3'd1;
  localparam logic [2:0] DATA_BITS = 3'd2;
  localparam logic [2:0] STOP_BIT  = 3'd3;
  localparam logic [2:0] BREAK     = 3'd4;

  localparam int DATA_BITS_N = 8;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/sync2.sv
// sync2: a two-flop synchronizer that brings an asynchronous pin input into the clk domain.
//   RESET_VAL sets the value both flops take during reset. Choose the idle level of the pin,
//   so that no spurious edge appears when reset is released.
// Ports:
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset
//   d      in  asynchronous input
//   q      out synchronized output, delayed by 2 cycles
module sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: an 8N1 asynchronous serial receiver. Bits arrive LSB first.
//   It holds each received byte in a single-entry output register and raises sticky
//   overrun and framing-error flags.
//   Build option UART_RX_MAJORITY_EN: when defined, each sample point takes a 2-of-3 majority
//   of rx_s at the nominal count -2, -1 and 0. When undefined, it takes a single sample.
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   rx         in   serial line (asynchronous to clk, idles high)
//   re         in   read strobe: consumes dout and clears the error flags
//   dout       out  [7:0] last received byte
//   valid      out  dout holds an unread byte
//   overrun    out  sticky: a byte was dropped while valid=1
//   frame_err  out  sticky: the stop bit was sampled low
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | line idle; waits for rx_s low
// START_BIT | counts to mid start bit; confirms low, or treats it as a glitch
// DATA_BITS | samples 8 data bits, one per CLKS_PER_BIT, LSB first
// STOP_BIT  | samples the stop bit; delivers the byte or flags a framing error
// BREAK     | line held low after a bad stop; waits for the line to go high
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       re,
  output logic [7:0] dout,
  output logic       valid,
  output logic       overrun,
  output logic       frame_err
);

  localparam logic [15:0] HALF_CNT = 16'((CLKS_PER_BIT - 1) / 2);
  localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  LAST_IDX = 3'(DATA_BITS_N - 1);

  logic        rx_s;
  logic        bit_val;
  logic [2:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        deliver;
  logic        frame_evt;

  sync2 #(.RESET_VAL(1'b1)) u_sync_rx (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  // Holds rx_s from the previous two cycles. The counter advances once per cycle
  // inside a state, so at the nominal count these are the -1 and -2 captures.
  logic [1:0] hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hist_q <= 2'b11;
    else        hist_q <= {hist_q[0], rx_s};
  end

  assign bit_val = maj3(rx_s, hist_q[0], hist_q[1]);
`else
  assign bit_val = rx_s;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 16'd1;
    idx_d     = idx_q;
    shift_d   = shift_q;
    deliver   = 1'b0;
    frame_evt = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START_BIT;
      end
      START_BIT: begin
        if (cnt_q == HALF_CNT) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = bit_val ? IDLE : DATA_BITS;
        end
      end
      DATA_BITS: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          shift_d = {bit_val, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == LAST_IDX) state_d = STOP_BIT;
        end
      end
      STOP_BIT: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
          if (bit_val) begin
            deliver = 1'b1;
            state_d = IDLE;
          end else begin
            frame_evt = 1'b1;
            state_d   = BREAK;
          end
        end
      end
      BREAK: begin
        // Wait for the line to go high, so a held-low line cannot look like a new start bit.
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  // A read clears everything. A delivery or error in the same cycle then takes priority over the read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout      <= '0;
      valid     <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (re) begin
        valid     <= 1'b0;
        overrun   <= 1'b0;
        frame_err <= 1'b0;
      end
      if (deliver) begin
        if (!valid || re) begin
          dout  <= shift_q;
          valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
      if (frame_evt) frame_err <= 1'b1;
    end
  end

endmodule
